// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 32x32 register file write port: buffers ALU and
// memory writebacks in program order, drains one per cycle, and forwards queued data.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [4:0]    mem_reg,
  input  logic [31:0]   mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [4:0]    alu_reg,
  input  logic [31:0]   alu_data,
  output logic          alu_ready,
  output logic          RegWrite,
  output logic [4:0]    WriteReg,
  output logic [31:0]   WriteD,
  input  logic [4:0]    q_reg1,
  output logic          q_hit1,
  output logic [31:0]   q_data1,
  input  logic [4:0]    q_reg2,
  output logic          q_hit2,
  output logic [31:0]   q_data2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][4:0]  ent_reg_q, ent_reg_d;
  logic [DEPTH-1:0][31:0] ent_data_q, ent_data_d;
  logic [AW-1:0]          head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [AW:0]            count_q, count_d, free;
  logic                   mem_push, alu_push, pop;

  always_comb begin
    // Free space is taken before this cycle's pop; the drain is not credited.
    free      = DEPTH_C - count_q;
    mem_ready = ~rst & (free != '0);
    alu_ready = ~rst & ((free > (AW+1)'(1)) | (~mem_valid & (free != '0)));
    mem_push  = mem_valid & mem_ready & (mem_reg != '0);
    alu_push  = alu_valid & alu_ready & (alu_reg != '0);
    pop       = (count_q != '0);

    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    wr_ptr     = tail_q;
    if (mem_push) begin
      ent_reg_d[wr_ptr]  = mem_reg;
      ent_data_d[wr_ptr] = mem_data;
      wr_ptr             = wr_ptr + AW'(1);
    end
    if (alu_push) begin
      ent_reg_d[wr_ptr]  = alu_reg;
      ent_data_d[wr_ptr] = alu_data;
      wr_ptr             = wr_ptr + AW'(1);
    end
    tail_d  = wr_ptr;
    head_d  = pop ? head_q + AW'(1) : head_q;
    count_d = count_q + (AW+1)'(mem_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_reg_q  <= '0;
      ent_data_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      ent_reg_q  <= ent_reg_d;
      ent_data_q <= ent_data_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    RegWrite = pop;
    WriteReg = pop ? ent_reg_q[head_q]  : '0;
    WriteD   = pop ? ent_data_q[head_q] : '0;
    count    = count_q;
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  function automatic logic [32:0] lookup(input logic [4:0] q);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((i < 32'(count_q)) && (q != '0) && (ent_reg_q[idx] == q))
        res = {1'b1, ent_data_q[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {q_hit1, q_data1} = lookup(q_reg1);
    {q_hit2, q_data2} = lookup(q_reg2);
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomised bench for regfile_writeback_queue against a queue-based model of the
// writeback rules, plus literal expectations for the directed scenarios.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid, mem_ready, alu_ready;
  logic [4:0]  mem_reg, alu_reg, q_reg1, q_reg2, WriteReg;
  logic [31:0] mem_data, alu_data, WriteD, q_data1, q_data2;
  logic        RegWrite, q_hit1, q_hit2;
  logic [AW:0] count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteD(WriteD),
    .q_reg1(q_reg1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_reg2(q_reg2), .q_hit2(q_hit2), .q_data2(q_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf   [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] fwd(input logic [4:0] q);
    logic [32:0] res = '0;
    if (q != 0)
      foreach (mq[i]) if (mq[i].r == q) res = {1'b1, mq[i].d};
    return res;
  endfunction

  // One cycle: drive at posedge+1, compare at posedge+2, update model on the edge.
  task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic [4:0] r1, input logic [4:0] r2);
    int sz, fr;
    logic e_mr, e_ar;
    logic [32:0] f1, f2;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    q_reg1 = r1; q_reg2 = r2;
    #1;
    sz   = mq.size();
    fr   = DEPTH - sz;
    e_mr = (fr >= 1);
    e_ar = (fr >= 2) || (!mv && fr >= 1);
    f1   = fwd(r1);
    f2   = fwd(r2);
    chk("mem_ready", 32'(mem_ready), 32'(e_mr));
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("count",     32'(count),     32'(sz));
    chk("RegWrite",  32'(RegWrite),  32'(sz != 0));
    chk("WriteReg",  32'(WriteReg),  sz != 0 ? 32'(mq[0].r) : 32'd0);
    chk("WriteD",    WriteD,         sz != 0 ? mq[0].d : 32'd0);
    chk("q_hit1",    32'(q_hit1),    32'(f1[32]));
    chk("q_data1",   q_data1,        f1[31:0]);
    chk("q_hit2",    32'(q_hit2),    32'(f2[32]));
    chk("q_data2",   q_data2,        f2[31:0]);
    if (RegWrite) dut_rf[WriteReg] = WriteD;
    @(posedge clk);
    if (sz != 0) begin
      model_rf[mq[0].r] = mq[0].d;
      void'(mq.pop_front());
    end
    if (mv && e_mr && mr != 0) mq.push_back('{mr, md});
    if (av && e_ar && ar != 0) mq.push_back('{ar, ad});
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    rst = 1'b1;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    q_reg1 = 0; q_reg2 = 0;
    #12;
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_RegWrite",  32'(RegWrite),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single mem write, one-edge latency to the register file.
    step(1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("t1_RegWrite", 32'(RegWrite), 32'd1);
    chk("t1_WriteReg", 32'(WriteReg), 32'd5);
    chk("t1_WriteD",   WriteD,        32'hAAAA0001);
    chk("t1_count",    32'(count),    32'd1);
    idle(5'd0);
    chk("t1_count_after", 32'(count), 32'd0);

    // Same-edge mem and alu to the same register: mem older, alu youngest.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
    chk("t2_WriteD_first", WriteD,        32'h11);
    chk("t2_q_hit1",       32'(q_hit1),   32'd1);
    chk("t2_q_data1",      q_data1,       32'h22);
    idle(5'd3);
    chk("t2_WriteD_second", WriteD, 32'h22);
    idle(5'd0);

    // Back-to-back dual requests with the drain running.
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(i + 8), $urandom, 1'b1, 5'(i + 16), $urandom, 5'(i + 16), 5'(i + 8));
    chk("t3_count", 32'(count), 32'd3);
    #0 chk("t3_alu_ready_blocked", 32'(alu_ready), 32'd0);
    for (int i = 0; i < 4; i++) idle(5'd0);

    // r0 writes are accepted but never queued.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
    chk("t4_count",    32'(count),    32'd0);
    chk("t4_RegWrite", 32'(RegWrite), 32'd0);
    chk("t4_q_hit1",   32'(q_hit1),   32'd0);

    // Asynchronous reset with three entries queued.
    step(1'b1, 5'd7, 32'h70, 1'b1, 5'd9, 32'h90, 5'd0, 5'd0);
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 5'd0, 5'd0);
    chk("t5_count_filled", 32'(count), 32'd3);
    mem_valid = 0; alu_valid = 0; q_reg1 = 5'd10;
    #2 rst = 1'b1;
    #1;
    chk("t5_RegWrite", 32'(RegWrite), 32'd0);
    chk("t5_count",    32'(count),    32'd0);
    chk("t5_q_hit1",   32'(q_hit1),   32'd0);
    chk("t5_mem_ready", 32'(mem_ready), 32'd0);
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    chk("t5_drain_reg", 32'(WriteReg), 32'd12);
    idle(5'd0);

    // Random traffic including wrap-around and r0 requests.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    for (int i = 0; i < DEPTH + 1; i++) idle(5'd0);
    for (int i = 0; i < 32; i++) chk("regfile", dut_rf[i], model_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
